// File: rtl/cluster_sequencer.sv
// ---------------------------------------------------------------------------
// cluster_sequencer: streams x/w/b from RAMs into the MAC cluster and stores
// its activations. Optional stall watchdog: SEQ_WATCHDOG_EN. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cluster_sequencer #(
  parameter int INPUT_SIZE  = 784,
  parameter int OUTPUT_SIZE = 48,
  parameter int NUM_PASSES  = 2,
`ifdef SEQ_WATCHDOG_EN
  parameter int WDOG_CYCLES = 4096,
`endif
  localparam int XA_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1,
  localparam int WA_W = (INPUT_SIZE * NUM_PASSES > 1) ? $clog2(INPUT_SIZE * NUM_PASSES) : 1,
  localparam int BA_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1,
  localparam int AA_W = (OUTPUT_SIZE * NUM_PASSES > 1) ? $clog2(OUTPUT_SIZE * NUM_PASSES) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [XA_W-1:0] x_addr,
  input  logic [11:0]     x_rdata,
  output logic [WA_W-1:0] w_addr,
  input  logic [63:0]     w_rdata,
  output logic [BA_W-1:0] b_addr,
  input  logic [63:0]     b_rdata,
  output logic [11:0]     x_tdata,
  output logic            x_tvalid,
  input  logic            x_tready,
  output logic [63:0]     w_tdata,
  output logic            w_tvalid,
  input  logic            w_tready,
  output logic [63:0]     b_tdata,
  output logic            b_tvalid,
  input  logic            b_tready,
  input  logic [63:0]     a_tdata,
  input  logic            a_tvalid,
  output logic            a_tready,
`ifdef SEQ_WATCHDOG_EN
  output logic            err,
`endif
  output logic            act_we,
  output logic [AA_W-1:0] act_addr,
  output logic [3:0]      act_wdata
);

  localparam int IDX_N = (INPUT_SIZE > OUTPUT_SIZE) ? INPUT_SIZE : OUTPUT_SIZE;
  localparam int IW    = (IDX_N > 1) ? $clog2(IDX_N) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_STREAM, S_DRAIN, S_NEXT, S_FIN
  } state_e;

  state_e          state_q, state_d;
  logic [BA_W-1:0] pass_q, pass_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            svalid_q, svalid_d;
  logic            aready_q, aready_d;
  logic            act_we_q, act_we_d;
  logic [AA_W-1:0] act_addr_q, act_addr_d;
  logic [3:0]      act_wdata_q, act_wdata_d;

  logic          fire;
  logic          accept;
  logic          last_in;
  logic          last_out;
  logic [IW-1:0] stream_idx;
  logic          unused_inputs;

  // Valid/ready are masked by reset so nothing can complete on the reset cycle.
  assign x_tvalid = svalid_q & RST;
  assign w_tvalid = svalid_q & RST;
  assign b_tvalid = svalid_q & RST;
  assign a_tready = aready_q & RST;

  assign fire     = x_tvalid & x_tready & w_tvalid & w_tready;
  assign accept   = a_tvalid & a_tready;
  assign last_in  = (idx_q == IW'(INPUT_SIZE - 1));
  assign last_out = (idx_q == IW'(OUTPUT_SIZE - 1));

  // Look one beat ahead on a fire so the RAM output advances with no bubble.
  always_comb begin
    stream_idx = '0;
    if (state_q == S_STREAM) begin
      stream_idx = (fire && !last_in) ? idx_q + IW'(1) : idx_q;
    end
  end

  assign x_addr    = XA_W'(stream_idx);
  assign w_addr    = WA_W'(pass_q) * WA_W'(INPUT_SIZE) + WA_W'(stream_idx);
  assign b_addr    = pass_q;
  assign x_tdata   = x_rdata;
  assign w_tdata   = w_rdata;
  assign b_tdata   = b_rdata;
  assign busy      = busy_q;
  assign done      = done_q;
  assign act_we    = act_we_q;
  assign act_addr  = act_addr_q;
  assign act_wdata = act_wdata_q;

  assign unused_inputs = ^{a_tdata[63:4], b_tready};

`ifdef SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;
  assign err = err_q;
`endif

  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    idx_d       = idx_q;
    svalid_d    = svalid_q;
    aready_d    = aready_q;
    done_d      = 1'b0;
    act_we_d    = 1'b0;
    act_addr_d  = act_addr_q;
    act_wdata_d = act_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PREP;
          pass_d  = '0;
          idx_d   = '0;
        end
      end
      S_PREP: begin
        state_d  = S_STREAM;
        svalid_d = 1'b1;
      end
      S_STREAM: begin
        if (fire) begin
          if (last_in) begin
            idx_d    = '0;
            svalid_d = 1'b0;
            aready_d = 1'b1;
            state_d  = S_DRAIN;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (accept) begin
          act_we_d    = 1'b1;
          act_addr_d  = AA_W'(pass_q) * AA_W'(OUTPUT_SIZE) + AA_W'(idx_q);
          act_wdata_d = a_tdata[3:0];
          if (last_out) begin
            idx_d    = '0;
            aready_d = 1'b0;
            state_d  = S_NEXT;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_NEXT: begin
        idx_d = '0;
        if (pass_q == BA_W'(NUM_PASSES - 1)) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          pass_d  = pass_q + BA_W'(1);
          state_d = S_PREP;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef SEQ_WATCHDOG_EN
    wdog_d = wdog_q;
    err_d  = err_q;
    if (state_q == S_IDLE && start) err_d = 1'b0;
    if (fire || accept || state_d != state_q) begin
      wdog_d = '0;
    end else if (state_q == S_STREAM || state_q == S_DRAIN) begin
      if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
        state_d  = S_IDLE;
        svalid_d = 1'b0;
        aready_d = 1'b0;
        idx_d    = '0;
        pass_d   = '0;
        err_d    = 1'b1;
        wdog_d   = '0;
      end else begin
        wdog_d = wdog_q + WW'(1);
      end
    end
`endif
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      pass_q      <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      svalid_q    <= 1'b0;
      aready_q    <= 1'b0;
      act_we_q    <= 1'b0;
      act_addr_q  <= '0;
      act_wdata_q <= '0;
`ifdef SEQ_WATCHDOG_EN
      wdog_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      svalid_q    <= svalid_d;
      aready_q    <= aready_d;
      act_we_q    <= act_we_d;
      act_addr_q  <= act_addr_d;
      act_wdata_q <= act_wdata_d;
`ifdef SEQ_WATCHDOG_EN
      wdog_q      <= wdog_d;
      err_q       <= err_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cluster_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cluster_sequencer: directed bench for cluster_sequencer (small layer).
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cluster_sequencer;

  localparam int IS = 4;
  localparam int OS = 3;
  localparam int NP = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [1:0]  x_addr;
  logic [11:0] x_rdata;
  logic [2:0]  w_addr;
  logic [63:0] w_rdata;
  logic [0:0]  b_addr;
  logic [63:0] b_rdata;
  logic [11:0] x_tdata;
  logic        x_tvalid, w_tvalid, b_tvalid, a_tready;
  logic        x_tready = 1'b1;
  logic        w_tready = 1'b1;
  logic        b_tready = 1'b1;
  logic [63:0] w_tdata, b_tdata;
  logic [63:0] a_tdata = '0;
  logic        a_tvalid = 1'b0;
  logic        act_we;
  logic [2:0]  act_addr;
  logic [3:0]  act_wdata;
`ifdef SEQ_WATCHDOG_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int valid_cycles = 0;
  logic tog_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [11:0] prev_x = '0;
  logic [63:0] fx[$], fw[$], fb[$], acts[$];

  cluster_sequencer #(
    .INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .NUM_PASSES(NP)
`ifdef SEQ_WATCHDOG_EN
    , .WDOG_CYCLES(16)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .busy(busy), .done(done),
    .x_addr(x_addr), .x_rdata(x_rdata), .w_addr(w_addr), .w_rdata(w_rdata),
    .b_addr(b_addr), .b_rdata(b_rdata),
    .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready),
    .w_tdata(w_tdata), .w_tvalid(w_tvalid), .w_tready(w_tready),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid), .b_tready(b_tready),
    .a_tdata(a_tdata), .a_tvalid(a_tvalid), .a_tready(a_tready),
`ifdef SEQ_WATCHDOG_EN
    .err(err),
`endif
    .act_we(act_we), .act_addr(act_addr), .act_wdata(act_wdata)
  );

  always #5 CLK = ~CLK;

  // RAM models with one-cycle read latency
  always @(posedge CLK) begin
    x_rdata <= 12'(x_addr) + 12'd1;
    w_rdata <= 64'hA000 + 64'(w_addr);
    b_rdata <= 64'hB0 + 64'(b_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (x_tvalid) valid_cycles++;
    if (done) done_cnt++;
    if (prev_stall) check("stall_hold", 64'(x_tdata), 64'(prev_x));
    prev_stall = x_tvalid && !(x_tready && w_tready);
    prev_x     = x_tdata;
    if (x_tvalid && x_tready && w_tvalid && w_tready) begin
      fx.push_back(64'(x_tdata));
      fw.push_back(w_tdata);
      fb.push_back(b_tdata);
    end
    if (act_we) acts.push_back(64'({act_addr, act_wdata}));
  end

  initial begin
    forever begin
      @(posedge CLK); #1;
      if (tog_en) x_tready = ~x_tready;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic clear_mon();
    fx.delete(); fw.delete(); fb.delete(); acts.delete();
    done_cnt = 0;
    valid_cycles = 0;
  endtask

  task automatic send_acts(input logic [11:0] d);
    int k = 0;
    int guard = 0;
    a_tvalid = 1'b1;
    a_tdata  = {60'hABCDEF012345678, d[11:8]};
    while (k < 3 && guard < 100) begin
      @(negedge CLK);
      guard++;
      if (a_tready) begin
        @(posedge CLK); #1;
        k++;
        if (k < 3) a_tdata = {60'hABCDEF012345678, d[11-4*k -: 4]};
      end
    end
    a_tvalid = 1'b0;
    if (k != 3) check("act_timeout", 64'(k), 64'd3);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 60) begin
      tick();
      g++;
    end
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic check_run();
    logic [23:0] tbl = 24'h1235F0;
    check("fire_count", 64'(fx.size()), 64'd8);
    for (int i = 0; i < fx.size() && i < 8; i++) begin
      check($sformatf("x_beat%0d", i), fx[i], 64'((i % 4) + 1));
      check($sformatf("w_beat%0d", i), fw[i], 64'h A000 + 64'(i));
      check($sformatf("b_beat%0d", i), fb[i], 64'h B0 + 64'(i / 4));
    end
    check("act_count", 64'(acts.size()), 64'd6);
    for (int i = 0; i < acts.size() && i < 6; i++)
      check($sformatf("act%0d", i), acts[i], 64'(i * 16) + 64'(tbl[23-4*i -: 4]));
    check("done_count", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_xvalid", 64'(x_tvalid), 64'd0);
    check("rst_bvalid", 64'(b_tvalid), 64'd0);
    check("rst_aready", 64'(a_tready), 64'd0);
    check("rst_actwe", 64'(act_we), 64'd0);
    RST = 1'b1;
    tick();

    // Plain layer, all readies high
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    check("prep_busy", 64'(busy), 64'd1);
    check("prep_xaddr", 64'(x_addr), 64'd0);
    check("prep_waddr", 64'(w_addr), 64'd0);
    check("prep_baddr", 64'(b_addr), 64'd0);
    send_acts(12'h123);
    send_acts(12'h5F0);
    wait_idle();
    check_run();

    // x_tready toggling, start pulsed during DRAIN
    clear_mon();
    tog_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int g = 0; g < 100 && !a_tready; g++) tick();
    check("drain_reached", 64'(a_tready), 64'd1);
    start = 1'b1; tick(); start = 1'b0;
    send_acts(12'h123);
    send_acts(12'h5F0);
    wait_idle();
    tog_en = 1'b0;
    x_tready = 1'b1;
    check_run();

    // Reset during the second stream beat
    tick();
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    RST = 1'b0; tick(); RST = 1'b1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_xvalid", 64'(x_tvalid), 64'd0);
    check("mid_rst_wvalid", 64'(w_tvalid), 64'd0);
    check("mid_rst_bvalid", 64'(b_tvalid), 64'd0);
    check("mid_rst_fires", 64'(fx.size()), 64'd1);
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    send_acts(12'h123);
    send_acts(12'h5F0);
    wait_idle();
    check_run();

`ifdef SEQ_WATCHDOG_EN
    // Weight stream never ready: watchdog must abort
    tick();
    clear_mon();
    w_tready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int g = 0; g < 100 && !err; g++) tick();
    @(negedge CLK);
    check("wdog_err", 64'(err), 64'd1);
    check("wdog_busy", 64'(busy), 64'd0);
    check("wdog_xvalid", 64'(x_tvalid), 64'd0);
    check("wdog_stall_cycles", 64'(valid_cycles), 64'd16);
    check("wdog_done", 64'(done_cnt), 64'd0);
    w_tready = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
